// File: rtl/red_pitaya_calib_loader.sv
// rtl/red_pitaya_calib_loader.sv - sys_bus initiator that loads and verifies the calibration bank
// Snapshots eight gain/offset fields on start, writes them from BASE upward, optionally reads back.
module red_pitaya_calib_loader #(
   parameter int          DWM    = 16,
   parameter int          DWS    = 14,
   parameter logic [31:0] BASE   = 32'h40,
   parameter bit          VERIFY = 1'b1,
   parameter int          TMO    = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0][DWM-1:0] adc_mul,
   input  logic [1:0][DWS-1:0] adc_sum,
   input  logic [1:0][DWM-1:0] dac_mul,
   input  logic [1:0][DWS-1:0] dac_sum,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [1:0]          fail_code,
   output logic [2:0]          fail_idx,
   output logic [31:0]         bus_addr,
   output logic [31:0]         bus_wdata,
   output logic                bus_wen,
   output logic                bus_ren,
   input  logic [31:0]         bus_rdata,
   input  logic                bus_ack,
   input  logic                bus_err
);

   localparam int          TW     = (TMO < 2) ? 1 : $clog2(TMO);
   localparam logic [31:0] MASK_M = 32'((64'd1 << DWM) - 64'd1);
   localparam logic [31:0] MASK_S = 32'((64'd1 << DWS) - 64'd1);

   typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_END} state_t;

   state_t        state;
   logic [2:0]    idx;
   logic [2:0]    nidx;
   logic [TW-1:0] tmo_cnt;
   logic [31:0]   snap    [8];
   logic [31:0]   in_word [8];
   logic [31:0]   mask;
   logic          in_wr, in_rd, waiting;
   logic          ack_ok, ack_err, mismatch, timeout, word_ok;

   // Even indices are gain words, odd indices are offset words.
   always_comb begin
      in_word[0] = 32'($signed(adc_mul[0]));
      in_word[1] = 32'($signed(adc_sum[0]));
      in_word[2] = 32'($signed(adc_mul[1]));
      in_word[3] = 32'($signed(adc_sum[1]));
      in_word[4] = 32'($signed(dac_mul[0]));
      in_word[5] = 32'($signed(dac_sum[0]));
      in_word[6] = 32'($signed(dac_mul[1]));
      in_word[7] = 32'($signed(dac_sum[1]));
   end

   always_comb begin
      in_wr    = (state == S_WR_REQ) || (state == S_WR_WAIT);
      in_rd    = (state == S_RD_REQ) || (state == S_RD_WAIT);
      waiting  = (state == S_WR_WAIT) || (state == S_RD_WAIT);
      mask     = idx[0] ? MASK_S : MASK_M;
      ack_ok   = (in_wr || in_rd) && bus_ack && !bus_err;
      ack_err  = (in_wr || in_rd) && bus_ack && bus_err;
      mismatch = in_rd && ack_ok && (((bus_rdata ^ snap[idx]) & mask) != 32'd0);
      timeout  = waiting && !bus_ack && (tmo_cnt == TW'(TMO - 1));
      word_ok  = ack_ok && !mismatch && (in_rd || !VERIFY);
      nidx     = idx + 3'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         tmo_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= '0;
         fail_idx  <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wen   <= 1'b0;
         bus_ren   <= 1'b0;
         for (int i = 0; i < 8; i++) snap[i] <= '0;
      end else begin
         bus_wen <= 1'b0;
         bus_ren <= 1'b0;
         if (ack_err || mismatch || timeout) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_idx  <= idx;
            fail_code <= ack_err ? 2'd2 : (mismatch ? 2'd3 : 2'd1);
         end else if (word_ok) begin
            if (idx == 3'd7) begin
               state <= S_END;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               idx       <= nidx;
               state     <= S_WR_REQ;
               bus_wen   <= 1'b1;
               bus_addr  <= BASE + {27'd0, nidx, 2'b00};
               bus_wdata <= snap[nidx];
               tmo_cnt   <= '0;
            end
         end else if (ack_ok) begin
            // Write acknowledged with readback enabled: read the same address.
            state   <= S_RD_REQ;
            bus_ren <= 1'b1;
            tmo_cnt <= '0;
         end else begin
            case (state)
               S_IDLE, S_END: begin
                  state <= S_IDLE;
                  if (start) begin
                     for (int i = 0; i < 8; i++) snap[i] <= in_word[i];
                     done      <= 1'b0;
                     fail      <= 1'b0;
                     fail_code <= '0;
                     fail_idx  <= '0;
                     idx       <= '0;
                     tmo_cnt   <= '0;
                     state     <= S_WR_REQ;
                     busy      <= 1'b1;
                     bus_wen   <= 1'b1;
                     bus_addr  <= BASE;
                     bus_wdata <= in_word[0];
                  end
               end
               S_WR_REQ: state <= S_WR_WAIT;
               S_RD_REQ: state <= S_RD_WAIT;
               default:  tmo_cnt <= tmo_cnt + 1'b1;
            endcase
         end
      end
   end

endmodule
